// File: rtl/mc_controller_fsm.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback and
// drives the datapath enables and selects, trapping on unsupported opcodes.
module mc_controller_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd15
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] aluop;
    logic       branch;
    logic       jump;

    always_comb begin
        next_state = state;
        case (state)
            FETCH:    next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECR;
                    OP_I:         next_state = EXECI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
                    default:      next_state = TRAP;
                endcase
            end
            MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MemReady ? MEMWB : MEMREAD;
            MEMWB:    next_state = FETCH;
            MEMWRITE: next_state = MemReady ? FETCH : MEMWRITE;
            EXECR:    next_state = ALUWB;
            EXECI:    next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            JAL:      next_state = ALUWB;
            BEQ:      next_state = FETCH;
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    // Outputs are registered from the state being entered, so they are valid
    // for the whole cycle spent in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            AdrSrc    <= 1'b0;
            MemWrite  <= 1'b0;
            RegWrite  <= 1'b0;
            ResultSrc <= 2'b10;
            ALUSrcA   <= 2'b00;
            ALUSrcB   <= 2'b10;
            aluop     <= 2'b00;
            branch    <= 1'b0;
            jump      <= 1'b0;
            Illegal   <= 1'b0;
        end else begin
            state     <= next_state;
            AdrSrc    <= 1'b0;
            MemWrite  <= 1'b0;
            RegWrite  <= 1'b0;
            ResultSrc <= 2'b00;
            ALUSrcA   <= 2'b00;
            ALUSrcB   <= 2'b00;
            aluop     <= 2'b00;
            branch    <= 1'b0;
            jump      <= 1'b0;
            Illegal   <= 1'b0;
            case (next_state)
                FETCH: begin
                    ResultSrc <= 2'b10;
                    ALUSrcB   <= 2'b10;
                end
                DECODE: begin
                    ALUSrcA <= 2'b01;
                    ALUSrcB <= 2'b01;
                end
                MEMADR: begin
                    ALUSrcA <= 2'b10;
                    ALUSrcB <= 2'b01;
                end
                MEMREAD:  AdrSrc <= 1'b1;
                MEMWB: begin
                    ResultSrc <= 2'b01;
                    RegWrite  <= 1'b1;
                end
                MEMWRITE: begin
                    AdrSrc   <= 1'b1;
                    MemWrite <= 1'b1;
                end
                EXECR: begin
                    ALUSrcA <= 2'b10;
                    aluop   <= 2'b10;
                end
                EXECI: begin
                    ALUSrcA <= 2'b10;
                    ALUSrcB <= 2'b01;
                    aluop   <= 2'b10;
                end
                ALUWB:    RegWrite <= 1'b1;
                JAL: begin
                    ALUSrcA <= 2'b01;
                    ALUSrcB <= 2'b10;
                    jump    <= 1'b1;
                end
                BEQ: begin
                    ALUSrcA <= 2'b10;
                    aluop   <= 2'b01;
                    branch  <= 1'b1;
                end
                TRAP:     Illegal <= 1'b1;
                default: ;
            endcase
        end
    end

    // Fetch strobes must follow MemReady in the same cycle, so they stay combinational.
    assign IRWrite = (state == FETCH) && MemReady;
    assign PCWrite = IRWrite | jump | (branch & Zero);
    assign State   = state;

    always_comb begin
        case (op)
            OP_LW, OP_I: ImmSrc = 2'b00;
            OP_SW:       ImmSrc = 2'b01;
            OP_BEQ:      ImmSrc = 2'b10;
            OP_JAL:      ImmSrc = 2'b11;
            default:     ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_mc_controller_fsm.sv
// Randomized self-checking bench for mc_controller_fsm against a per-instruction
// state-sequence model with a table of expected outputs per state.
module tb_mc_controller_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;
    int seq[$];

    mc_controller_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function logic [31:0] dutVec();
        return {11'b0, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State};
    endfunction

    // Expected outputs straight from the per-state output table and decode rules.
    function automatic logic [31:0] modelVec(input int st, input bit mr, input bit z,
                                             input logic [6:0] o, input logic [2:0] f3, input bit f7);
        bit pcu = 0, br = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0, pcw;
        logic [1:0] res = 2'b00, sa = 2'b00, sb = 2'b00, imm, aop = 2'b00;
        logic [2:0] ac;
        logic [3:0] s4 = st[3:0];
        case (st)
            0:  begin sb = 2'b10; res = 2'b10; irw = mr; pcu = mr; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1;
            4:  begin res = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2'b10; aop = 2'b10; end
            7:  rw = 1;
            8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            9:  begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            10: begin sa = 2'b10; aop = 2'b01; br = 1; end
            15: ill = 1;
            default: ;
        endcase
        case (o)
            OP_SW:   imm = 2'b01;
            OP_BEQ:  imm = 2'b10;
            OP_JAL:  imm = 2'b11;
            default: imm = 2'b00;
        endcase
        ac = 3'b000;
        if (aop == 2'b01) ac = 3'b001;
        else if (aop == 2'b10) begin
            if (f3 == 3'b000 && o[5] && f7) ac = 3'b001;
            else if (f3 == 3'b010) ac = 3'b101;
            else if (f3 == 3'b110) ac = 3'b011;
            else if (f3 == 3'b111) ac = 3'b010;
        end
        pcw = pcu | (br & z);
        return {11'b0, pcw, adr, mw, irw, rw, res, sa, sb, imm, ac, ill, s4};
    endfunction

    task automatic buildSeq(input logic [6:0] o);
        case (o)
            OP_LW:   seq = '{0, 1, 2, 3, 4};
            OP_SW:   seq = '{0, 1, 2, 5};
            OP_R:    seq = '{0, 1, 6, 7};
            OP_I:    seq = '{0, 1, 8, 7};
            OP_JAL:  seq = '{0, 1, 9, 7};
            OP_BEQ:  seq = '{0, 1, 10};
            default: begin
                seq = '{0, 1};
                repeat (10) seq.push_back(15);
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                                 input bit mr, input bit z);
        op = o; funct3 = f3; funct7b5 = f7; MemReady = mr; Zero = z;
    endtask

    // Walks one instruction, starting just after a clock edge with the DUT in FETCH.
    // zmode: 0/1 force Zero, 2 random. stall: cycles of MemReady=0 in memory states.
    task automatic runInstr(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                            input bit randMr, input int stall, input int zmode);
        int st, waited;
        bit mr, z, isWait;
        buildSeq(o);
        for (int i = 0; i < seq.size(); i++) begin
            st = seq[i];
            waited = 0;
            do begin
                isWait = (st == 0 || st == 3 || st == 5);
                if (randMr) mr = ($urandom_range(0, 3) != 0);
                else mr = !(isWait && st != 0 && waited < stall);
                z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
                applyStimulus(o, f3, f7, mr, z);
                @(negedge clk);
                checkOutput($sformatf("st%0d_op%02h", st, o), dutVec(), modelVec(st, mr, z, o, f3, f7));
                @(posedge clk);
                #1;
                waited++;
            end while (isWait && !mr);
        end
    endtask

    task automatic doReset();
        #2;
        MemReady = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("reset_async", dutVec(), modelVec(0, 0, Zero, op, funct3, funct7b5));
        @(negedge clk);
        checkOutput("reset_hold", dutVec(), modelVec(0, 0, Zero, op, funct3, funct7b5));
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic measureLatency(input logic [6:0] o, input int expected, input string name);
        int cnt = 1;
        applyStimulus(o, 3'b000, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (State == 4'd0) break;
            cnt++;
        end
        checkOutput(name, cnt, expected);
    endtask

    initial begin
        logic [6:0] legal [6];
        legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
        reset = 1'b1;
        applyStimulus(7'b0, 3'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("power_on_reset", dutVec(), modelVec(0, 0, 0, 7'b0, 3'b0, 1'b0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        runInstr(OP_R, 3'b000, 1'b1, 1'b0, 0, 2);
        runInstr(OP_LW, 3'b010, 1'b0, 1'b0, 3, 2);
        runInstr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 1);
        runInstr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        runInstr(OP_SW, 3'b010, 1'b0, 1'b0, 2, 2);

        measureLatency(OP_LW, 5, "lat_lw");
        measureLatency(OP_SW, 4, "lat_sw");
        measureLatency(OP_R, 4, "lat_r");
        measureLatency(OP_I, 4, "lat_i");
        measureLatency(OP_JAL, 4, "lat_jal");
        measureLatency(OP_BEQ, 3, "lat_beq");

        for (int n = 0; n < 80; n++) begin
            runInstr(legal[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'b1, 0, 2);
        end

        runInstr(7'b1111111, 3'b000, 1'b0, 1'b1, 0, 2);
        doReset();

        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        MemReady = 1'b0;
        #1;
        checkOutput("mw_before_reset", {State, MemWrite}, {4'd5, 1'b1});
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mw_async_reset", {State, MemWrite, IRWrite, PCWrite}, {4'd0, 3'b000});
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        runInstr(OP_I, 3'b111, 1'b0, 1'b1, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
